// File: rtl/dff_rr_arbiter.sv
// Round-robin write arbiter for a shared WIDTH-bit register.
// One owner at a time, limited to MAX_HOLD consecutive grant cycles.
module dff_rr_arbiter #(
   parameter  int NREQ     = 4,
   parameter  int WIDTH    = 8,
   parameter  int MAX_HOLD = 4,
   localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       we,
   input  logic [NREQ*WIDTH-1:0] d,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      q,
   output logic [OW-1:0]         owner,
   output logic                  busy,
   output logic                  timeout
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_next;
   logic [OW-1:0]   ptr, ptr_next;
   logic [HW-1:0]   hold_cnt, hold_next;
   logic [NREQ-1:0] gnt_next;
   logic [WIDTH-1:0] q_next;
   logic [OW-1:0]   owner_next;
   logic            timeout_next;

   logic [OW-1:0]   sel;
   logic            sel_found;
   logic [OW-1:0]   after_owner;
   logic            at_limit;

   // Rotating-priority scan starting at ptr; the first requester found wins.
   always_comb begin
      sel       = ptr;
      sel_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!sel_found && req[(int'(ptr) + k) % NREQ]) begin
            sel_found = 1'b1;
            sel       = OW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   // Explicit wrap keeps ptr legal when NREQ is not a power of two.
   assign after_owner = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
   assign at_limit    = (hold_cnt == HW'(MAX_HOLD - 1));

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      state_next   = state;
      ptr_next     = ptr;
      hold_next    = hold_cnt;
      gnt_next     = gnt;
      q_next       = q;
      owner_next   = owner;
      timeout_next = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_next = GRANT;
               gnt_next   = NREQ'(1) << sel;
               owner_next = sel;
               hold_next  = '0;
            end
         end
         GRANT: begin
            if (we[owner])
               q_next = d[int'(owner)*WIDTH +: WIDTH];
            if (!req[owner] || at_limit) begin
               state_next   = IDLE;
               gnt_next     = '0;
               ptr_next     = after_owner;
               timeout_next = at_limit && req[owner];
            end else begin
               hold_next = hold_cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         q        <= '0;
         owner    <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_next;
         ptr      <= ptr_next;
         hold_cnt <= hold_next;
         gnt      <= gnt_next;
         q        <= q_next;
         owner    <= owner_next;
         timeout  <= timeout_next;
      end
   end

   assign busy = (state == GRANT);

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Scoreboard bench for dff_rr_arbiter: expected outputs are queued as each
// cycle's stimulus is applied and compared after the following clock edge.
module tb_dff_rr_arbiter;

   localparam int NREQ = 4;
   localparam int WIDTH = 8;
   localparam int MAX_HOLD = 4;
   localparam int OW = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       we;
   logic [NREQ*WIDTH-1:0] d;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      q;
   logic [OW-1:0]         owner;
   logic                  busy;
   logic                  timeout;

   typedef struct {
      string           tag;
      logic [NREQ-1:0] gnt;
      logic [WIDTH-1:0] q;
      logic [OW-1:0]   owner;
      logic            busy;
      logic            timeout;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [WIDTH-1:0] q_model;

   dff_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .we      (we),
      .d       (d),
      .gnt     (gnt),
      .q       (q),
      .owner   (owner),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Queue the expected post-edge outputs, let one edge pass, then compare.
   task automatic step(input string tag, input logic [NREQ-1:0] g, input logic [OW-1:0] o,
                       input logic b, input logic t);
      exp_t e;
      exp_t r;
      e.tag = tag; e.gnt = g; e.q = q_model; e.owner = o; e.busy = b; e.timeout = t;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      r = exp_q.pop_front();
      check({r.tag, ".gnt"},     32'(gnt),     32'(r.gnt));
      check({r.tag, ".q"},       32'(q),       32'(r.q));
      check({r.tag, ".owner"},   32'(owner),   32'(r.owner));
      check({r.tag, ".busy"},    32'(busy),    32'(r.busy));
      check({r.tag, ".timeout"}, 32'(timeout), 32'(r.timeout));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      q_model = '0;
      rst_n = 1'b0; req = 4'b1111; we = 4'b1111; d = 32'hDEAD_BEEF;
      step("reset0", 4'b0000, 2'd0, 1'b0, 1'b0);
      step("reset1", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Single request from requester 2.
      rst_n = 1'b1; req = 4'b0100; we = 4'b0100; d = {8'h00, 8'hA5, 8'h00, 8'h00};
      step("single_arb", 4'b0100, 2'd2, 1'b1, 1'b0);
      q_model = 8'hA5;
      step("single_wr", 4'b0100, 2'd2, 1'b1, 1'b0);
      req = 4'b0000; we = 4'b0000;
      step("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);

      // Reset again so the round-robin starts at pointer 0.
      rst_n = 1'b0; q_model = '0;
      step("reset2", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1; req = 4'b1111; we = 4'b0000; d = 32'h1234_5678;
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < MAX_HOLD; c++)
            step($sformatf("rr_g%0d_c%0d", g, c), 4'(1 << (g % NREQ)), OW'(g % NREQ), 1'b1, 1'b0);
         step($sformatf("rr_g%0d_gap", g), 4'b0000, OW'(g % NREQ), 1'b0, 1'b1);
      end

      // Voluntary release by requester 1 (pointer is now 1).
      req = 4'b1010; we = 4'b0000;
      step("vol_arb", 4'b0010, 2'd1, 1'b1, 1'b0);
      we = 4'b0010; d = {8'h00, 8'h00, 8'h5A, 8'h00};
      q_model = 8'h5A;
      step("vol_wr", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b1001; we = 4'b0000;
      step("vol_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
      step("vol_next", 4'b1000, 2'd3, 1'b1, 1'b0);

      // Write isolation: only the owner's enable counts.
      req = 4'b1000; we = 4'b0111; d = {8'h44, 8'h33, 8'h22, 8'h11};
      step("iso_block", 4'b1000, 2'd3, 1'b1, 1'b0);
      we = 4'b1000; q_model = 8'h44;
      step("iso_write", 4'b1000, 2'd3, 1'b1, 1'b0);

      // Reset mid-grant with the owner writing: no write, everything cleared.
      rst_n = 1'b0; d = {8'h77, 8'h00, 8'h00, 8'h00}; q_model = '0;
      step("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1; we = 4'b0000;
      step("post_rst_arb", 4'b1000, 2'd3, 1'b1, 1'b0);
      we = 4'b1000; d = {8'h99, 8'h00, 8'h00, 8'h00}; q_model = 8'h99;
      step("post_rst_wr", 4'b1000, 2'd3, 1'b1, 1'b0);
      we = 4'b0000;
      step("hold_c2", 4'b1000, 2'd3, 1'b1, 1'b0);
      step("hold_c3", 4'b1000, 2'd3, 1'b1, 1'b0);
      // Request drops on the same edge the limit is hit: no timeout pulse.
      req = 4'b0000;
      step("limit_drop", 4'b0000, 2'd3, 1'b0, 1'b0);

      // In IDLE, write enables are ignored.
      we = 4'b1111; d = 32'hFFFF_FFFF;
      step("idle_we", 4'b0000, 2'd3, 1'b0, 1'b0);

      // Pointer wrapped to 0 after owner 3 released.
      req = 4'b0011; we = 4'b0000;
      step("wrap_arb", 4'b0001, 2'd0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
